// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, fetches over req/ack, presents one instruction to IF/ID.
// Latency: >= 2 cycles/instr (FETCH+HOLD); stallreq_if high while a fetch is outstanding; stall[0] holds HOLD.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_pending_br;
    logic [31:0] r_br_pc;
    logic [31:0] r_redir_pc;
    logic [31:0] r_pc_q;
    logic [31:0] r_inst_q;

    state_t      w_state_nxt;
    logic [31:0] w_pc_nxt;
    logic        w_pending_br_nxt;
    logic [31:0] w_br_pc_nxt;
    logic [31:0] w_redir_pc_nxt;
    logic [31:0] w_pc_q_nxt;
    logic [31:0] w_inst_q_nxt;
    logic        w_hold_adv;
    logic        w_unused;

    // Only the PC/IF stall bit matters here; later-stage bits are handled elsewhere.
    assign w_unused   = ^stall[5:1];
    assign w_hold_adv = (r_state == S_HOLD) && !stall[0] && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pending_br <= 1'b0;
            r_br_pc      <= 32'h0;
            r_redir_pc   <= 32'h0;
            r_pc_q       <= 32'h0;
            r_inst_q     <= 32'h0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pending_br <= w_pending_br_nxt;
            r_br_pc      <= w_br_pc_nxt;
            r_redir_pc   <= w_redir_pc_nxt;
            r_pc_q       <= w_pc_q_nxt;
            r_inst_q     <= w_inst_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pending_br_nxt = r_pending_br;
        w_br_pc_nxt      = r_br_pc;
        w_redir_pc_nxt   = r_redir_pc;
        w_pc_q_nxt       = r_pc_q;
        w_inst_q_nxt     = r_inst_q;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
                if (flush) w_pc_nxt = new_pc;
            end
            S_FETCH: begin
                if (flush) begin
                    // With ack the fetched word is stale: refetch from the handler directly.
                    if (imem_ack) begin
                        w_pc_nxt = new_pc;
                    end else begin
                        w_redir_pc_nxt = new_pc;
                        w_state_nxt    = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    w_pc_q_nxt   = r_pc;
                    w_inst_q_nxt = imem_rdata;
                    w_state_nxt  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_pc_nxt    = new_pc;
                    w_state_nxt = S_FETCH;
                end else if (!stall[0]) begin
                    if (branch_flag_i)     w_pc_nxt = branch_target_i;
                    else if (r_pending_br) w_pc_nxt = r_br_pc;
                    else                   w_pc_nxt = r_pc_q + PC_STEP;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Memory cannot abort a request, so keep the old address up until ack.
                if (flush) w_redir_pc_nxt = new_pc;
                if (imem_ack) begin
                    w_pc_nxt    = flush ? new_pc : r_redir_pc;
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (flush || w_hold_adv) begin
            w_pending_br_nxt = 1'b0;
        end else if (branch_flag_i) begin
            w_pending_br_nxt = 1'b1;
            w_br_pc_nxt      = branch_target_i;
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        imem_addr   = 32'h0;
        if_pc       = 32'h0;
        if_inst     = 32'h0;
        stallreq_if = 1'b0;
        case (r_state)
            S_FETCH, S_DRAIN: begin
                imem_req    = 1'b1;
                imem_addr   = r_pc;
                stallreq_if = 1'b1;
            end
            S_HOLD: begin
                if_pc   = r_pc_q;
                if_inst = r_inst_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; the producer side of the IF/ID pipeline register. Drives if_pc/if_inst into IF/ID.
- Owns the PC. Issues requests to instruction memory over a req/ack handshake with variable latency.
- Honours stall/flush from pipeline control, applies branch redirects after the delay slot, and raises stallreq_if while a fetch is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
stall  in  6  pipeline stall vector; bit 0 = PC/IF stage stop
flush  in  1  exception flush, highest priority
new_pc  in  32  flush target (exception handler)
branch_flag_i  in  1  branch taken, from ID (1-cycle pulse)
branch_target_i  in  32  branch target, from ID
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address
imem_ack  in  1  data valid and request complete
imem_rdata  in  32  fetched instruction
if_pc  out  32  PC of the presented instruction, to IF/ID
if_inst  out  32  presented instruction, to IF/ID
stallreq_if  out  1  stall request to pipeline control

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_PC.
  - pending_br=0, redir_pc=0, pc_q=0, inst_q=0.
  - All outputs 0.
  - Reset mid-transaction drops imem_req immediately; a late ack after reset release in IDLE is ignored.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE:
  - Outputs 0, stallreq_if=0.
  - Next edge goes to FETCH.
  - Flush in IDLE: pc<=new_pc.
- FETCH:
  - imem_req=1, imem_addr=pc. Address stays stable until ack.
  - if_pc=0, if_inst=0 (bubble); stallreq_if=1.
  - On imem_ack with no flush: pc_q<=pc, inst_q<=imem_rdata, go HOLD. Ack in the same cycle as req is legal (0-wait).
  - On flush without ack: redir_pc<=new_pc, go DRAIN.
  - On flush with ack: data discarded, pc<=new_pc, stay FETCH.
- HOLD:
  - imem_req=0, if_pc=pc_q, if_inst=inst_q, stallreq_if=0.
  - If stall[0]=1: hold everything.
  - If stall[0]=0: the instruction is consumed at this edge; pc<=next_pc, go FETCH.
  - next_pc priority: branch_flag_i ? branch_target_i : pending_br ? br_pc : pc_q+PC_STEP. pending_br clears when used.
  - Flush in HOLD (overrides stall): pc<=new_pc, pending_br<=0, go FETCH.
- DRAIN:
  - imem_req=1 with the old address held; if_pc=if_inst=0; stallreq_if=1.
  - On ack: data dropped, pc<=redir_pc, go FETCH.
  - A further flush in DRAIN overwrites redir_pc.
- Branch capture:
  - branch_flag_i arriving outside a HOLD-advance edge sets pending_br=1 and br_pc=branch_target_i.
  - The redirect therefore takes effect after the delay-slot instruction currently in IF is consumed.
  - Flush clears pending_br.
  - A branch in the same cycle as flush is ignored.
- Arithmetic: pc+PC_STEP wraps modulo 2^32, with no overflow signalling. pc[1:0] is not checked.
- Throughput: minimum 2 cycles per instruction with 0-wait memory (FETCH+HOLD).

Test Plan:
- Reset sequence:
  - Stimulus: rst=0 for 3 cycles, release; memory 0-wait returns 32'h2408_0001 at addr 0.
  - Response: all outputs 0 during reset; cycle 1 IDLE; cycle 2 imem_req=1, addr=0; cycle 3 if_pc=0, if_inst=32'h2408_0001, stallreq_if=0.
- Variable latency:
  - Stimulus: ack delayed 3 cycles per fetch from addr 0x100.
  - Response: stallreq_if=1 and if_inst=0 for the full wait, addr held at 0x100; next request is 0x104, then 0x108.
- Stall hold:
  - Stimulus: stall=6'b000011 for 4 cycles while in HOLD with pc_q=0x20.
  - Response: if_pc=0x20 stable and imem_req=0 throughout; after release the next addr is 0x24.
- Branch/delay slot:
  - Stimulus: branch_flag_i pulse with target 0x400 while the delay slot at 0x14 is in FETCH.
  - Response: 0x14 is presented, then the next request is 0x400 (not 0x18).
- Flush during outstanding request:
  - Stimulus: flush with new_pc=0x180 while FETCH for 0x30 is waiting, ack 2 cycles later with data 0xDEAD_BEEF.
  - Response: DRAIN with addr held at 0x30; 0xDEAD_BEEF is never presented; next request is 0x180; pending branch cleared.
- Reset mid-fetch:
  - Stimulus: rst=0 asserted while imem_req=1.
  - Response: imem_req falls in the same cycle (async); after release, fetch restarts at RESET_PC.
